fifo_sync_ctl_p: RTL and testbench
==================================

Name: fifo_sync_ctl_p

Overview:
Parametrised single-clock FIFO, the successor to the fixed 18K/11-bit-pointer FIFO controller. It owns its storage array, read/write pointers, fill counter and the full flag set (FULL/FMO/FWM/OVERRUN, EMPTY/EPO/EWM/UNDERRUN). It adds three things the fixed controller lacks: a parametrised width and depth, a first-word-fall-through (FWFT) read mode, and a live fill-level output. It sits under the BRAM wrapper level as the synchronous-FIFO engine for fabric FIFOs.

Parameters:
DATA_WIDTH, 18, width of the stored word.
ADDR_WIDTH, 10, pointer width; DEPTH = 2**ADDR_WIDTH words.
FWFT, 0, 0 = standard read (data one cycle after REN_i); 1 = first-word-fall-through.

Ports:
CLK_i  in  1  single clock; all logic on the rising edge.
RESET_i  in  1  synchronous reset, active-high.
FLUSH_i  in  1  synchronous flush, active-high: empties the FIFO and clears sticky flags.
WEN_i  in  1  write request.
WDATA_i  in  DATA_WIDTH  write data.
REN_i  in  1  read request (standard mode) / pop request (FWFT mode).
RDATA_o  out  DATA_WIDTH  registered read data.
RVALID_o  out  1  standard: 1-cycle pulse marking new RDATA_o. FWFT: RDATA_o holds the head word.
UPAF_i  in  ADDR_WIDTH  almost-full threshold, in free words.
UPAE_i  in  ADDR_WIDTH  almost-empty threshold, in stored words.
COUNT_o  out  ADDR_WIDTH+1  words held; includes the FWFT output register.
FULL_o, FMO_o, FWM_o, OVERRUN_o  out  1 each  full, full-minus-one, almost-full watermark, sticky overrun.
EMPTY_o, EPO_o, EWM_o, UNDERRUN_o  out  1 each  empty, empty-plus-one, almost-empty watermark, sticky underrun.

Behaviour:
- Reset (RESET_i=1 at an edge): pointers=0, COUNT_o=0, RDATA_o=0, RVALID_o=0, OVERRUN_o=0, UNDERRUN_o=0. Resulting flags: EMPTY_o=1, EWM_o=1, FULL_o=0, FMO_o=0, FWM_o=0, EPO_o=0. RESET_i has priority over FLUSH_i and over all requests.
- Flush: identical to reset, except RDATA_o holds its value. Requests in the flush cycle are ignored and do not set sticky flags.
- Write accept: wa = WEN_i & ~FULL_o. Stores WDATA_i at wptr, then wptr++ (wraps modulo DEPTH).
  - A write while FULL_o=1 is dropped and sets OVERRUN_o. This holds even if a read is accepted in the same cycle.
- Read accept (standard): ra = REN_i & ~EMPTY_o.
  - RDATA_o <= mem[rptr], rptr++, and RVALID_o=1 in the following cycle only.
  - Read latency is 1 cycle. RDATA_o holds when no read is accepted.
  - A read while EMPTY_o=1 is dropped and sets UNDERRUN_o, even if a write is accepted in the same cycle.
- FWFT mode:
  - The output register is stage 0. RVALID_o = ~EMPTY_o.
  - Pop: ra = REN_i & RVALID_o. On pop, the register reloads from mem[rptr] if the array is non-empty; otherwise RVALID_o goes to 0.
  - A write into an empty FIFO, or while the register is invalid, bypasses to RDATA_o. RVALID_o=1 the cycle after the write.
  - REN_i while RVALID_o=0 sets UNDERRUN_o.
  - Simultaneous pop and write with one word held: the new word goes straight to the register, RVALID_o stays 1, COUNT_o stays 1.
- COUNT_o: next = COUNT_o + wa - ra. Simultaneous accepted read and write leaves the count unchanged. COUNT_o never exceeds DEPTH and never goes below 0.
- Flags are registered, updated from the next count on the same edge:
  - FULL = (count == DEPTH)
  - FMO = (count == DEPTH-1)
  - EMPTY = (count == 0)
  - EPO = (count == 1)
- Watermarks are combinational from COUNT_o and the live thresholds:
  - FWM_o = (DEPTH - COUNT_o) <= UPAF_i
  - EWM_o = COUNT_o <= UPAE_i
  - Threshold changes take effect immediately.
- Sticky flags stay set until reset or flush.
- Pointer wrap: pointers are ADDR_WIDTH bits; full/empty is resolved by COUNT_o, not by pointer comparison. Data must stay intact across wrap.
- The storage array has no reset; contents are undefined after reset and unobservable until written.

Test Plan:
1. Standard mode, ADDR_WIDTH=4. After reset, write 16 words 0x00..0x0F. Required: FMO_o=1 after 15 writes; FULL_o=1 and COUNT_o=16 after 16. A 17th write sets OVERRUN_o; COUNT_o stays 16.
2. Drain the full FIFO with REN_i held 16 cycles. Required: RDATA_o = 0x00..0x0F with RVALID_o each cycle, 1-cycle latency; EPO_o before the last word; EMPTY_o=1 at the end. An extra REN_i sets UNDERRUN_o; RDATA_o holds 0x0F.
3. Simultaneous WEN_i/REN_i at COUNT_o=5 for 40 cycles. Required: COUNT_o stays 5, data order preserved across two pointer wraps, no sticky flag set.
4. UPAF_i=3, UPAE_i=2, fill from 0. Required: EWM_o=1 for counts 0-2; FWM_o rises at COUNT_o=13. Changing UPAF_i to 5 at count 12 raises FWM_o the same cycle.
5. FWFT=1, write 0xA5 into empty. Required: RDATA_o=0xA5 and RVALID_o=1 the next cycle, with no REN_i. Pop plus simultaneous write 0x5A gives RDATA_o=0x5A and COUNT_o=1.
6. With COUNT_o=7 and OVERRUN_o=1, assert FLUSH_i together with WEN_i. Required next cycle: COUNT_o=0, EMPTY_o=1, OVERRUN_o=0, RDATA_o unchanged. RESET_i mid-burst gives all outputs at their reset values the following cycle.

Source files
------------

// File: rtl/fifo_sync_ctl_p.sv
// Single-clock FIFO engine with parametrised width/depth, optional first-word-fall-through and live fill level.
// Latency: standard mode RDATA_o one cycle after an accepted REN_i; FWFT mode head word visible the cycle after the write.
// Backpressure: writes are refused while FULL_o, reads while EMPTY_o; refused requests set sticky OVERRUN_o / UNDERRUN_o.
//
// Ports:
//   CLK_i, RESET_i (sync, active-high), FLUSH_i (sync empty + clear sticky flags, RDATA_o held)
//   WEN_i/WDATA_i write side; REN_i read (standard) or pop (FWFT); RDATA_o/RVALID_o read side
//   UPAF_i/UPAE_i live almost-full (free words) / almost-empty (stored words) thresholds
//   COUNT_o fill level (includes the FWFT output register); FULL/FMO/FWM/OVERRUN, EMPTY/EPO/EWM/UNDERRUN flags
module fifo_sync_ctl_p #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int FWFT       = 0
) (
  input  logic                  CLK_i,
  input  logic                  RESET_i,
  input  logic                  FLUSH_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  input  logic [ADDR_WIDTH-1:0] UPAF_i,
  input  logic [ADDR_WIDTH-1:0] UPAE_i,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  // Storage has no reset; a word is only ever observed after it was written.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  full_q, fmo_q, empty_q, epo_q;
  logic                  ovr_q, unr_q;

  logic wa, ra;
  logic mem_we;   // write WDATA_i into the array at wptr
  logic rd_mem;   // load RDATA from the array head and advance rptr
  logic rd_byp;   // load RDATA directly from WDATA_i (FWFT bypass)
  logic arr_has;  // FWFT: array holds at least one word behind the output register

  // In FWFT mode RVALID_o == ~EMPTY_o, so both modes share the same accept terms.
  assign wa = WEN_i & ~full_q;
  assign ra = REN_i & ~empty_q;

  // FWFT keeps the head word in the output register whenever count > 0,
  // so the array itself holds count-1 words.
  assign arr_has = (count_q > CNT_ONE);

  always_comb begin
    count_d = count_q;
    if (wa && !ra) begin
      count_d = count_q + CNT_ONE;
    end else if (ra && !wa) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    rd_mem = 1'b0;
    rd_byp = 1'b0;
    if (!RESET_i && !FLUSH_i) begin
      if (FWFT == 0) begin
        mem_we = wa;
        rd_mem = ra;
      end else if (empty_q) begin
        // Nothing held: a new word goes straight to the output register.
        rd_byp = wa;
      end else if (ra) begin
        if (arr_has) begin
          rd_mem = 1'b1;
          mem_we = wa;
        end else begin
          // Popping the only word: a simultaneous write replaces it directly.
          rd_byp = wa;
        end
      end else begin
        mem_we = wa;
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (mem_we) begin
      mem_q[wptr_q] <= WDATA_i;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      full_q   <= 1'b0;
      fmo_q    <= 1'b0;
      empty_q  <= 1'b1;
      epo_q    <= 1'b0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else if (FLUSH_i) begin
      // Same as reset but the last read word stays on RDATA_o.
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      full_q   <= 1'b0;
      fmo_q    <= 1'b0;
      empty_q  <= 1'b1;
      epo_q    <= 1'b0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      if (mem_we) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (rd_mem) begin
        rptr_q  <= rptr_q + PTR_ONE;
        rdata_q <= mem_q[rptr_q];
      end else if (rd_byp) begin
        rdata_q <= WDATA_i;
      end
      rvalid_q <= ra;
      count_q  <= count_d;
      // Flags track the post-edge count so they line up with COUNT_o.
      full_q   <= (count_d == CNT_FULL);
      fmo_q    <= (count_d == CNT_FULL - CNT_ONE);
      empty_q  <= (count_d == '0);
      epo_q    <= (count_d == CNT_ONE);
      // Refused requests are judged against the pre-edge flags, regardless
      // of what the other side accepts in the same cycle.
      ovr_q    <= ovr_q | (WEN_i & full_q);
      unr_q    <= unr_q | (REN_i & empty_q);
    end
  end

  assign RDATA_o    = rdata_q;
  assign RVALID_o   = (FWFT != 0) ? ~empty_q : rvalid_q;
  assign COUNT_o    = count_q;
  assign FULL_o     = full_q;
  assign FMO_o      = fmo_q;
  assign EMPTY_o    = empty_q;
  assign EPO_o      = epo_q;
  assign OVERRUN_o  = ovr_q;
  assign UNDERRUN_o = unr_q;

  // Watermarks follow the thresholds combinationally.
  assign FWM_o = ((CNT_FULL - count_q) <= {1'b0, UPAF_i});
  assign EWM_o = (count_q <= {1'b0, UPAE_i});

endmodule

// File: tb/tb_fifo_sync_ctl_p.sv
module tb_fifo_sync_ctl_p;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, flush, wen, ren;
  logic [DW-1:0] wdata;
  logic [AW-1:0] upaf, upae;

  logic [DW-1:0] s_rdata, f_rdata;
  logic [AW:0]   s_count, f_count;
  logic s_rvalid, s_full, s_fmo, s_fwm, s_ovr, s_empty, s_epo, s_ewm, s_unr;
  logic f_rvalid, f_full, f_fmo, f_fwm, f_ovr, f_empty, f_epo, f_ewm, f_unr;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO as a queue plus the sticky bits and the
  // standard-mode read register.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_srd;
  logic          m_srv, m_ovr, m_unr;

  always #5 clk = ~clk;

  fifo_sync_ctl_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
    .CLK_i(clk), .RESET_i(rst), .FLUSH_i(flush), .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren),
    .RDATA_o(s_rdata), .RVALID_o(s_rvalid), .UPAF_i(upaf), .UPAE_i(upae), .COUNT_o(s_count),
    .FULL_o(s_full), .FMO_o(s_fmo), .FWM_o(s_fwm), .OVERRUN_o(s_ovr),
    .EMPTY_o(s_empty), .EPO_o(s_epo), .EWM_o(s_ewm), .UNDERRUN_o(s_unr)
  );

  fifo_sync_ctl_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
    .CLK_i(clk), .RESET_i(rst), .FLUSH_i(flush), .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren),
    .RDATA_o(f_rdata), .RVALID_o(f_rvalid), .UPAF_i(upaf), .UPAE_i(upae), .COUNT_o(f_count),
    .FULL_o(f_full), .FMO_o(f_fmo), .FWM_o(f_fwm), .OVERRUN_o(f_ovr),
    .EMPTY_o(f_empty), .EPO_o(f_epo), .EWM_o(f_ewm), .UNDERRUN_o(f_unr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rst) begin
      q.delete(); m_srd = '0; m_srv = 1'b0; m_ovr = 1'b0; m_unr = 1'b0;
    end else if (flush) begin
      q.delete(); m_srv = 1'b0; m_ovr = 1'b0; m_unr = 1'b0;
    end else begin
      if (wen && was_full)  m_ovr = 1'b1;
      if (ren && was_empty) m_unr = 1'b1;
      m_srv = ren && !was_empty;
      if (ren && !was_empty) m_srd = q.pop_front();
      if (wen && !was_full)  q.push_back(wdata);
    end
  endtask

  task automatic chk_flags(input string p, input logic [AW:0] cnt, input logic full, input logic fmo,
                           input logic fwm, input logic ovr, input logic empty, input logic epo,
                           input logic ewm, input logic unr);
    int n;
    n = q.size();
    chk({p, "count"}, cnt, n);
    chk({p, "full"},  full,  n == DEPTH);
    chk({p, "fmo"},   fmo,   n == DEPTH - 1);
    chk({p, "empty"}, empty, n == 0);
    chk({p, "epo"},   epo,   n == 1);
    chk({p, "fwm"},   fwm,   (DEPTH - n) <= int'(upaf));
    chk({p, "ewm"},   ewm,   n <= int'(upae));
    chk({p, "ovr"},   ovr,   m_ovr);
    chk({p, "unr"},   unr,   m_unr);
  endtask

  task automatic check_all();
    chk_flags("s_", s_count, s_full, s_fmo, s_fwm, s_ovr, s_empty, s_epo, s_ewm, s_unr);
    chk_flags("f_", f_count, f_full, f_fmo, f_fwm, f_ovr, f_empty, f_epo, f_ewm, f_unr);
    chk("s_rvalid", s_rvalid, m_srv);
    chk("s_rdata",  s_rdata,  m_srd);
    chk("f_rvalid", f_rvalid, q.size() > 0);
    if (q.size() > 0) chk("f_rdata", f_rdata, q[0]);
  endtask

  // Inputs are held across one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    wen = w; wdata = d; ren = r;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    upaf = 4'd3; upae = 4'd2;
    step();
    rst = 1'b0;
    chk("rst_empty", s_empty, 1'b1);
    chk("rst_ewm", s_ewm, 1'b1);
    chk("rst_count", s_count, 0);
    chk("rst_rdata", s_rdata, 0);

    // Fill to full, then one refused write.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      if (i == 14) chk("fmo_at_15", s_fmo, 1'b1);
    end
    chk("full_at_16", s_full, 1'b1);
    chk("count_16", s_count, 16);
    drive(1'b1, 8'hEE, 1'b0);
    chk("overrun_set", s_ovr, 1'b1);
    chk("count_stays_16", s_count, 16);

    // Drain with REN held; each word arrives one cycle after its request.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1);
      chk("drain_data", s_rdata, i);
      chk("drain_rvalid", s_rvalid, 1'b1);
      if (i == 14) chk("epo_before_last", s_epo, 1'b1);
    end
    chk("drained_empty", s_empty, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("underrun_set", s_unr, 1'b1);
    chk("underrun_rdata_hold", s_rdata, 8'h0F);

    // Streaming at a constant level of 5 across two pointer wraps.
    flush = 1'b1; drive(1'b0, '0, 1'b0); flush = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h30 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, DW'(8'h40 + i), 1'b1);
      chk("stream_count", s_count, 5);
    end
    chk("stream_no_ovr", s_ovr, 1'b0);
    chk("stream_no_unr", s_unr, 1'b0);

    // Watermarks with live threshold change.
    flush = 1'b1; drive(1'b0, '0, 1'b0); flush = 1'b0;
    upaf = 4'd3; upae = 4'd2;
    #1;
    chk("ewm_at_0", s_ewm, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      drive(1'b1, DW'(8'h60 + c), 1'b0);
      if (c <= 2) chk("ewm_low", s_ewm, 1'b1);
      if (c == 3) chk("ewm_off_3", s_ewm, 1'b0);
      if (c == 12) begin
        chk("fwm_off_12", s_fwm, 1'b0);
        upaf = 4'd5; #1;
        chk("fwm_live_raise", s_fwm, 1'b1);
        upaf = 4'd3; #1;
        chk("fwm_live_drop", s_fwm, 1'b0);
      end
      if (c == 13) chk("fwm_on_13", s_fwm, 1'b1);
    end
    drive(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1);
    chk("count_7", s_count, 7);

    // Flush with a concurrent write.
    flush = 1'b1; drive(1'b1, 8'h77, 1'b0); flush = 1'b0;
    chk("flush_count", s_count, 0);
    chk("flush_empty", s_empty, 1'b1);
    chk("flush_ovr", s_ovr, 1'b0);
    chk("flush_rdata_hold", s_rdata, 8'h69);

    // FWFT bypass into empty and pop-with-write at one word.
    drive(1'b1, 8'hA5, 1'b0);
    chk("fwft_bypass_data", f_rdata, 8'hA5);
    chk("fwft_bypass_valid", f_rvalid, 1'b1);
    drive(1'b1, 8'h5A, 1'b1);
    chk("fwft_swap_data", f_rdata, 8'h5A);
    chk("fwft_swap_count", f_count, 1);
    chk("fwft_swap_valid", f_rvalid, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("fwft_pop_last", f_rvalid, 1'b0);

    // Randomised traffic with phases biased toward filling, draining and balance.
    for (int i = 0; i < 3000; i++) begin
      int ph, pw, pr;
      ph = (i / 250) % 3;
      pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 55;
      pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 55;
      if (i % 64 == 0) begin
        upaf = AW'($urandom_range(0, 15));
        upae = AW'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr);
      flush = 1'b0;
    end

    // Reset in the middle of a burst.
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(8'h90 + i), i[0]);
    rst = 1'b1; drive(1'b1, 8'hFF, 1'b1); rst = 1'b0;
    chk("rst_mid_count", s_count, 0);
    chk("rst_mid_rdata", s_rdata, 0);
    chk("rst_mid_rvalid", s_rvalid, 1'b0);
    chk("rst_mid_fwft_rdata", f_rdata, 0);
    chk("rst_mid_empty", f_empty, 1'b1);
    drive(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
